// File: rtl/alu_core.sv
// alu_core: registered integer ALU with zero and signed-overflow flags.
// The next result and flags are formed combinationally from the current
// operands. One output register bank captures them on each valid issue and
// holds them while no issue is present.
module alu_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] v_out,
  output logic             z,
  output logic             ovf,
  output logic             out_valid
);

  // Opcode encodings
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_NOR  = 3'b110;
  localparam logic [2:0] OP_SLTU = 3'b111;

  // Signed overflow of a + b: both operands share a sign and the sum's sign differs
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    add_ovf = (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  // Signed overflow of a - b: operand signs differ and the result's sign differs from a
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    sub_ovf = (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_lt_signed;
  logic             w_lt_unsigned;
  logic [WIDTH-1:0] w_result;
  logic             w_ovf;
  logic             w_zero;

  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_ovf;
  logic             r_valid;

  // Carry out of the MSB is dropped, so both arithmetic paths wrap modulo 2^WIDTH.
  assign w_sum         = A + B;
  assign w_diff        = A - B;
  assign w_lt_signed   = ($signed(A) < $signed(B));
  assign w_lt_unsigned = (A < B);

  // Select the next result and overflow flag from the opcode
  always_comb begin
    w_result = {WIDTH{1'b0}};
    w_ovf    = 1'b0;
    case (op)
      OP_ADD: begin
        w_result = w_sum;
        w_ovf    = add_ovf(A[WIDTH-1], B[WIDTH-1], w_sum[WIDTH-1]);
      end
      OP_SUB: begin
        w_result = w_diff;
        w_ovf    = sub_ovf(A[WIDTH-1], B[WIDTH-1], w_diff[WIDTH-1]);
      end
      OP_AND: begin
        w_result = A & B;
        w_ovf    = 1'b0;
      end
      OP_OR: begin
        w_result = A | B;
        w_ovf    = 1'b0;
      end
      OP_SLT: begin
        w_result = {{(WIDTH-1){1'b0}}, w_lt_signed};
        w_ovf    = 1'b0;
      end
      OP_XOR: begin
        w_result = A ^ B;
        w_ovf    = 1'b0;
      end
      OP_NOR: begin
        w_result = ~(A | B);
        w_ovf    = 1'b0;
      end
      OP_SLTU: begin
        w_result = {{(WIDTH-1){1'b0}}, w_lt_unsigned};
        w_ovf    = 1'b0;
      end
      default: begin
        w_result = {WIDTH{1'b0}};
        w_ovf    = 1'b0;
      end
    endcase
  end

  // The zero flag tracks exactly the value that is registered as the result
  assign w_zero = (w_result == {WIDTH{1'b0}});

  // Output bank: capture on a valid issue, otherwise hold; out_valid pulses once per issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= {WIDTH{1'b0}};
      r_zero   <= 1'b1;
      r_ovf    <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_result <= w_result;
        r_zero   <= w_zero;
        r_ovf    <= w_ovf;
      end else begin
        r_result <= r_result;
        r_zero   <= r_zero;
        r_ovf    <= r_ovf;
      end
    end
  end

  assign v_out     = r_result;
  assign z         = r_zero;
  assign ovf       = r_ovf;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed self-checking bench for alu_core.
module tb_alu_core;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  op;
  logic [31:0] v_out;
  logic        z;
  logic        ovf;
  logic        out_valid;

  int errors;
  int checks;

  alu_core #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .op        (op),
    .v_out     (v_out),
    .z         (z),
    .ovf       (ovf),
    .out_valid (out_valid)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one issue at the falling edge and sample 1 ns after the next rising edge
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o);
    @(negedge clk);
    A        = a;
    B        = b;
    op       = o;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    A        = 32'd0;
    B        = 32'd0;
    op       = 3'b000;
    #12;
    checks++;
    if ({v_out, z, ovf, out_valid} !== {32'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got v_out=%h z=%b ovf=%b out_valid=%b, want 0/1/0/0", v_out, z, ovf, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sub_equal();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    issue(32'd17, 32'd17, 3'b001);
    checks++;
    if ({v_out, z, ovf, out_valid} !== {32'd0, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL sub_equal: got v_out=%h z=%b ovf=%b out_valid=%b, want 0/1/0/1", v_out, z, ovf, out_valid);
    end
  endtask

  task automatic test_add_hold();
    issue(32'd905, 32'd267, 3'b000);
    checks++;
    if ({v_out, z, ovf, out_valid} !== {32'd1172, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL add_905_267: got v_out=%0d z=%b ovf=%b out_valid=%b, want 1172/0/0/1", v_out, z, ovf, out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      idle_cycle();
      checks++;
      if ({v_out, z, ovf, out_valid} !== {32'd1172, 1'b0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL hold_%0d: got v_out=%0d z=%b ovf=%b out_valid=%b, want 1172/0/0/0", i, v_out, z, ovf, out_valid);
      end
    end
  endtask

  task automatic test_logic_back_to_back();
    logic [2:0]  ops  [4];
    logic [31:0] exps [4];
    ops[0] = 3'b010; exps[0] = 32'h0000_2110;
    ops[1] = 3'b011; exps[1] = 32'h04A2_3DFF;
    ops[2] = 3'b101; exps[2] = 32'h04A2_1CEF;
    ops[3] = 3'b110; exps[3] = 32'hFB5D_C200;
    for (int i = 0; i < 4; i++) begin
      issue(32'h04A2_3135, 32'h0000_2DDA, ops[i]);
      checks++;
      if ({v_out, z, ovf, out_valid} !== {exps[i], 1'b0, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL logic_op_%b: got v_out=%h z=%b ovf=%b out_valid=%b, want %h/0/0/1", ops[i], v_out, z, ovf, out_valid, exps[i]);
      end
    end
    idle_cycle();
  endtask

  task automatic test_compare();
    logic [31:0] as  [5];
    logic [31:0] bs  [5];
    logic [2:0]  ops [5];
    logic [31:0] exps[5];
    as[0] = 32'd77738293;   bs[0] = 32'd11738;      ops[0] = 3'b100; exps[0] = 32'd0;
    as[1] = 32'd289;        bs[1] = 32'd1168;       ops[1] = 3'b100; exps[1] = 32'd1;
    as[2] = 32'h8000_0000;  bs[2] = 32'd1;          ops[2] = 3'b100; exps[2] = 32'd1;
    as[3] = 32'h8000_0000;  bs[3] = 32'd1;          ops[3] = 3'b111; exps[3] = 32'd0;
    as[4] = 32'h8000_0000;  bs[4] = 32'd0;          ops[4] = 3'b100; exps[4] = 32'd1;
    for (int i = 0; i < 5; i++) begin
      issue(as[i], bs[i], ops[i]);
      checks++;
      if ({v_out, z, ovf, out_valid} !== {exps[i], (exps[i] == 32'd0), 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL compare_%0d: got v_out=%h z=%b ovf=%b out_valid=%b, want %h", i, v_out, z, ovf, out_valid, exps[i]);
      end
    end
    issue(32'd12345, 32'd12345, 3'b100);
    checks++;
    if ({v_out, z} !== {32'd0, 1'b1}) begin
      errors++;
      $display("FAIL slt_equal: got v_out=%h z=%b, want 0/1", v_out, z);
    end
    idle_cycle();
  endtask

  task automatic test_overflow();
    issue(32'h7FFF_FFFF, 32'd1, 3'b000);
    checks++;
    if ({v_out, z, ovf} !== {32'h8000_0000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL add_ovf: got v_out=%h z=%b ovf=%b, want 80000000/0/1", v_out, z, ovf);
    end
    issue(32'h8000_0000, 32'd1, 3'b001);
    checks++;
    if ({v_out, z, ovf} !== {32'h7FFF_FFFF, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL sub_ovf: got v_out=%h z=%b ovf=%b, want 7fffffff/0/1", v_out, z, ovf);
    end
    issue(32'hFFFF_FFFF, 32'd1, 3'b000);
    checks++;
    if ({v_out, z, ovf} !== {32'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL add_wrap: got v_out=%h z=%b ovf=%b, want 0/1/0", v_out, z, ovf);
    end
    issue(32'd0, 32'd1, 3'b001);
    checks++;
    if ({v_out, z, ovf} !== {32'hFFFF_FFFF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sub_wrap: got v_out=%h z=%b ovf=%b, want ffffffff/0/0", v_out, z, ovf);
    end
    issue(32'h7FFF_FFFF, 32'd1, 3'b010);
    checks++;
    if ({v_out, z, ovf} !== {32'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL and_no_ovf: got v_out=%h z=%b ovf=%b, want 1/0/0", v_out, z, ovf);
    end
    idle_cycle();
  endtask

  task automatic test_async_reset();
    issue(32'd905, 32'd267, 3'b000);
    checks++;
    if ({v_out, out_valid} !== {32'd1172, 1'b1}) begin
      errors++;
      $display("FAIL pre_reset: got v_out=%0d out_valid=%b, want 1172/1", v_out, out_valid);
    end
    // in_valid is still high, so another result is pending for the next edge
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({v_out, z, ovf, out_valid} !== {32'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got v_out=%h z=%b ovf=%b out_valid=%b, want 0/1/0/0", v_out, z, ovf, out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({v_out, z, ovf, out_valid} !== {32'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_held: got v_out=%h z=%b ovf=%b out_valid=%b, want 0/1/0/0", v_out, z, ovf, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({v_out, z, ovf, out_valid} !== {32'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL post_release: got v_out=%h z=%b ovf=%b out_valid=%b, want 0/1/0/0", v_out, z, ovf, out_valid);
    end
    issue(32'd5, 32'd3, 3'b001);
    checks++;
    if ({v_out, z, ovf, out_valid} !== {32'd2, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL first_after_release: got v_out=%h z=%b ovf=%b out_valid=%b, want 2/0/0/1", v_out, z, ovf, out_valid);
    end
    idle_cycle();
  endtask

  // Test sequence
  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_sub_equal();
    test_add_hold();
    test_logic_back_to_back();
    test_compare();
    test_overflow();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
